// File: rtl/serializer_arb.sv
// Round-robin sequencer that shares one serializer among REQ_N requesters.
// Define SER_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module serializer_arb #(
  parameter int unsigned REQ_N      = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DATA_MOD_W = 4,
  parameter int unsigned BUSY_TO    = 3
) (
  input  logic                         clk_i,
  input  logic                         arst_ni,
  input  logic [REQ_N*DATA_W-1:0]      req_data_i,
  input  logic [REQ_N*DATA_MOD_W-1:0]  req_mod_i,
  input  logic [REQ_N-1:0]             req_val_i,
  output logic [REQ_N-1:0]             req_rdy_o,
  output logic [DATA_W-1:0]            ser_data_o,
  output logic [DATA_MOD_W-1:0]        ser_mod_o,
  output logic                         ser_val_o,
  input  logic                         ser_busy_i,
  output logic [$clog2(REQ_N)-1:0]     grant_id_o,
  output logic                         drop_o,
  output logic                         err_to_o
);
  localparam int unsigned IDX_W = $clog2(REQ_N);
  localparam int unsigned CNT_W = $clog2(BUSY_TO + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [DATA_MOD_W-1:0] mod_q, mod_d;
  logic                  val_q, val_d;
  logic                  drop_q, drop_d;
  logic                  err_q, err_d;

  logic [DATA_W-1:0]     data_arr [REQ_N];
  logic [DATA_MOD_W-1:0] mod_arr  [REQ_N];
  logic [IDX_W-1:0]      win;
  logic                  found;
  logic                  xfer;
  logic                  illegal;

  always_comb begin
    for (int unsigned k = 0; k < REQ_N; k++) begin
      data_arr[k] = req_data_i[k*DATA_W +: DATA_W];
      mod_arr[k]  = req_mod_i[k*DATA_MOD_W +: DATA_MOD_W];
    end
  end

  // Search order starts at ptr and wraps explicitly, so REQ_N need not be a power of 2.
  always_comb begin
    logic [IDX_W-1:0] cand;
`ifndef SER_ARB_FIXED_PRIO_EN
    int unsigned idx;
`endif
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < REQ_N; i++) begin
`ifdef SER_ARB_FIXED_PRIO_EN
      cand = IDX_W'(i);
`else
      idx = 32'(ptr_q) + i;
      if (idx >= REQ_N) idx = idx - REQ_N;
      cand = IDX_W'(idx);
`endif
      if (!found && req_val_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    xfer    = (state_q == IDLE) && !ser_busy_i && found;
    illegal = (mod_arr[win] == DATA_MOD_W'(1)) || (mod_arr[win] == DATA_MOD_W'(2));
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;
    drop_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          data_d  = data_arr[win];
          mod_d   = mod_arr[win];
          grant_d = win;
          cnt_d   = '0;
`ifdef SER_ARB_FIXED_PRIO_EN
          ptr_d   = '0;
`else
          ptr_d   = (win == IDX_W'(REQ_N - 1)) ? '0 : win + 1'b1;
`endif
          if (illegal) begin
            drop_d = 1'b1;
          end else begin
            val_d   = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (ser_busy_i) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TO - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!ser_busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_rdy_o = '0;
    if ((state_q == IDLE) && !ser_busy_i && found) req_rdy_o[win] = 1'b1;
  end

  assign ser_data_o = data_q;
  assign ser_mod_o  = mod_q;
  assign ser_val_o  = val_q;
  assign grant_id_o = grant_q;
  assign drop_o     = drop_q;
  assign err_to_o   = err_q;

endmodule

// File: tb/tb_serializer_arb.sv
// Table-driven bench for serializer_arb: one row per clock cycle, inputs plus expected outputs.
module tb_serializer_arb;
  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [63:0] req_data;
  logic [15:0] req_mod = '0;
  logic [3:0]  req_val = '0;
  logic [3:0]  req_rdy;
  logic [15:0] ser_data;
  logic [3:0]  ser_mod;
  logic        ser_val;
  logic        ser_busy = 1'b0;
  logic [1:0]  grant_id;
  logic        drop;
  logic        err_to;

  int checks = 0;
  int errors = 0;

  logic [15:0] dat [4] = '{16'h1111, 16'h2222, 16'hA5C3, 16'h4444};

  typedef struct {
    logic        rst;
    logic [3:0]  val;
    logic        busy;
    logic [15:0] mod;
    logic [3:0]  erdy;
    logic        esv;
    logic [1:0]  egnt;
    logic        edrop;
    logic        eerr;
    logic [15:0] edata;
    logic [3:0]  emod;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  assign req_data = {dat[3], dat[2], dat[1], dat[0]};

  serializer_arb #(.REQ_N(4), .DATA_W(16), .DATA_MOD_W(4), .BUSY_TO(3)) dut (
    .clk_i      (clk),
    .arst_ni    (arst_n),
    .req_data_i (req_data),
    .req_mod_i  (req_mod),
    .req_val_i  (req_val),
    .req_rdy_o  (req_rdy),
    .ser_data_o (ser_data),
    .ser_mod_o  (ser_mod),
    .ser_val_o  (ser_val),
    .ser_busy_i (ser_busy),
    .grant_id_o (grant_id),
    .drop_o     (drop),
    .err_to_o   (err_to)
  );

  task automatic add(input logic rst, input logic [3:0] val, input logic busy,
                     input logic [15:0] mod, input logic [3:0] erdy, input logic esv,
                     input logic [1:0] egnt, input logic edrop, input logic eerr,
                     input logic [15:0] edata, input logic [3:0] emod);
    vec_t v;
    v.rst = rst; v.val = val; v.busy = busy; v.mod = mod; v.erdy = erdy;
    v.esv = esv; v.egnt = egnt; v.edrop = edrop; v.eerr = eerr;
    v.edata = edata; v.emod = emod;
    tbl.push_back(v);
  endtask

  // One full accepted word with val held: accept, issue, busy high x2, busy low.
  task automatic add_window(input logic [3:0] val, input int k,
                            input logic [1:0] gprev, input logic [15:0] dprev);
    logic [1:0] kk;
    kk = 2'(k);
    add(0, val, 0, '0, 4'b0001 << k, 0, gprev, 0, 0, dprev, 4'h0);
    add(0, val, 0, '0, 4'b0000,      1, kk,    0, 0, dat[k], 4'h0);
    add(0, val, 1, '0, 4'b0000,      0, kk,    0, 0, dat[k], 4'h0);
    add(0, val, 1, '0, 4'b0000,      0, kk,    0, 0, dat[k], 4'h0);
    add(0, val, 0, '0, 4'b0000,      0, kk,    0, 0, dat[k], 4'h0);
  endtask

  task automatic build_table;
`ifdef SER_ARB_FIXED_PRIO_EN
    add(1, 4'b0000, 0, '0, 4'b0000, 0, 2'd0, 0, 0, 16'h0000, 4'h0);
    for (int w = 0; w < 4; w++) add_window(4'b1001, 0, 2'd0, (w == 0) ? 16'h0000 : dat[0]);
`else
    // Reset state, then a single request from requester 2
    add(1, 4'b0000, 0, '0, 4'b0000, 0, 2'd0, 0, 0, 16'h0000, 4'h0);
    add(0, 4'b0100, 0, '0, 4'b0100, 0, 2'd0, 0, 0, 16'h0000, 4'h0);
    add(0, 4'b0000, 0, '0, 4'b0000, 1, 2'd2, 0, 0, 16'hA5C3, 4'h0);
    add(0, 4'b0000, 1, '0, 4'b0000, 0, 2'd2, 0, 0, 16'hA5C3, 4'h0);
    add(0, 4'b0000, 1, '0, 4'b0000, 0, 2'd2, 0, 0, 16'hA5C3, 4'h0);
    add(0, 4'b0000, 0, '0, 4'b0000, 0, 2'd2, 0, 0, 16'hA5C3, 4'h0);
    // Reset clears a non-zero grant/data; then all four held -> 0,1,2,3,0
    add(1, 4'b0000, 0, '0, 4'b0000, 0, 2'd0, 0, 0, 16'h0000, 4'h0);
    for (int w = 0; w < 5; w++) begin
      if (w == 0) add_window(4'b1111, 0, 2'd0, 16'h0000);
      else        add_window(4'b1111, w % 4, 2'((w - 1) % 4), dat[(w - 1) % 4]);
    end
    // Requester 1 with mod=2 is dropped; requester 2 follows
    add(0, 4'b0110, 0, 16'h0020, 4'b0010, 0, 2'd0, 0, 0, 16'h1111, 4'h0);
    add(0, 4'b0100, 0, 16'h0000, 4'b0100, 0, 2'd1, 1, 0, 16'h2222, 4'h2);
    add(0, 4'b0000, 0, 16'h0000, 4'b0000, 1, 2'd2, 0, 0, 16'hA5C3, 4'h0);
    // Busy never rises: timeout three cycles after ser_val, then requester 3 accepted
    add(0, 4'b0000, 0, 16'h0000, 4'b0000, 0, 2'd2, 0, 0, 16'hA5C3, 4'h0);
    add(0, 4'b0000, 0, 16'h0000, 4'b0000, 0, 2'd2, 0, 0, 16'hA5C3, 4'h0);
    add(0, 4'b1000, 0, 16'h5000, 4'b1000, 0, 2'd2, 0, 1, 16'hA5C3, 4'h0);
    add(0, 4'b0000, 0, 16'h0000, 4'b0000, 1, 2'd3, 0, 0, 16'h4444, 4'h5);
    // Reset while in WAIT_DONE, then requester 0 wins first
    add(0, 4'b0000, 1, 16'h0000, 4'b0000, 0, 2'd3, 0, 0, 16'h4444, 4'h5);
    add(0, 4'b0000, 1, 16'h0000, 4'b0000, 0, 2'd3, 0, 0, 16'h4444, 4'h5);
    add(1, 4'b0000, 1, 16'h0000, 4'b0000, 0, 2'd0, 0, 0, 16'h0000, 4'h0);
    add(0, 4'b1111, 0, 16'h0000, 4'b0001, 0, 2'd0, 0, 0, 16'h0000, 4'h0);
    add(0, 4'b0000, 0, 16'h0000, 4'b0000, 1, 2'd0, 0, 0, 16'h1111, 4'h0);
    add(0, 4'b0000, 1, 16'h0000, 4'b0000, 0, 2'd0, 0, 0, 16'h1111, 4'h0);
    add(0, 4'b0000, 1, 16'h0000, 4'b0000, 0, 2'd0, 0, 0, 16'h1111, 4'h0);
    add(0, 4'b0000, 0, 16'h0000, 4'b0000, 0, 2'd0, 0, 0, 16'h1111, 4'h0);
    // External busy while IDLE blocks the grant until it falls
    add(0, 4'b0010, 1, 16'h0000, 4'b0000, 0, 2'd0, 0, 0, 16'h1111, 4'h0);
    add(0, 4'b0010, 1, 16'h0000, 4'b0000, 0, 2'd0, 0, 0, 16'h1111, 4'h0);
    add(0, 4'b0010, 0, 16'h0000, 4'b0010, 0, 2'd0, 0, 0, 16'h1111, 4'h0);
    add(0, 4'b0000, 0, 16'h0000, 4'b0000, 1, 2'd1, 0, 0, 16'h2222, 4'h0);
    add(0, 4'b0000, 1, 16'h0000, 4'b0000, 0, 2'd1, 0, 0, 16'h2222, 4'h0);
    add(0, 4'b0000, 1, 16'h0000, 4'b0000, 0, 2'd1, 0, 0, 16'h2222, 4'h0);
    add(0, 4'b0000, 0, 16'h0000, 4'b0000, 0, 2'd1, 0, 0, 16'h2222, 4'h0);
    // mod=1 is also illegal: dropped and the arbiter stays idle
    add(0, 4'b0100, 0, 16'h0100, 4'b0100, 0, 2'd1, 0, 0, 16'h2222, 4'h0);
    add(0, 4'b0000, 0, 16'h0000, 4'b0000, 0, 2'd2, 1, 0, 16'hA5C3, 4'h1);
    add(0, 4'b0000, 0, 16'h0000, 4'b0000, 0, 2'd2, 0, 0, 16'hA5C3, 4'h1);
`endif
  endtask

  initial begin
    build_table();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      arst_n   = !tbl[i].rst;
      req_val  = tbl[i].val;
      ser_busy = tbl[i].busy;
      req_mod  = tbl[i].mod;
      #1;
      checks++;
      if (req_rdy !== tbl[i].erdy || ser_val !== tbl[i].esv || grant_id !== tbl[i].egnt ||
          drop !== tbl[i].edrop || err_to !== tbl[i].eerr || ser_data !== tbl[i].edata ||
          ser_mod !== tbl[i].emod) begin
        errors++;
        $display("FAIL row %0d: got rdy=%b val=%b gnt=%0d drop=%b err=%b data=%h mod=%h, want rdy=%b val=%b gnt=%0d drop=%b err=%b data=%h mod=%h",
                 i, req_rdy, ser_val, grant_id, drop, err_to, ser_data, ser_mod,
                 tbl[i].erdy, tbl[i].esv, tbl[i].egnt, tbl[i].edrop, tbl[i].eerr,
                 tbl[i].edata, tbl[i].emod);
      end
      if (tbl[i].rst) begin
        checks++;
        if (req_rdy !== 4'b0000 || ser_val !== 1'b0 || grant_id !== 2'd0 || drop !== 1'b0 ||
            err_to !== 1'b0 || ser_data !== 16'h0000 || ser_mod !== 4'h0) begin
          errors++;
          $display("FAIL reset state row %0d: rdy=%b val=%b gnt=%0d drop=%b err=%b data=%h mod=%h",
                   i, req_rdy, ser_val, grant_id, drop, err_to, ser_data, ser_mod);
        end
      end
      if (tbl[i].eerr) begin
        checks++;
        if (err_to !== 1'b1 || ser_val !== 1'b0 || dut.state_q != dut.IDLE) begin
          errors++;
          $display("FAIL expired wait row %0d: err=%b val=%b state=%0d",
                   i, err_to, ser_val, dut.state_q);
        end
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
